pipe4_issue_ctrl: RTL and testbench
===================================

Name: pipe4_issue_ctrl

Overview:
In-order issue controller in front of the 4-stage pipelined ALU (pipe4stage).
- Buffers requester ops (rs1, rs2, rd, func, addr, write) in a small FIFO.
- Tracks in-flight destination registers with a scoreboard and stalls RAW hazards.
- Drives one op per cycle into the pipe as a one-cycle issue strobe with registered operand fields.
- Sole source of pipe stimulus; replaces direct bench driving of rs1/rs2/rd/func/addr/write.

Parameters:
QDEPTH, 4, FIFO depth in ops; power of 2, >=2
PIPE_LAT, 3, cycles rd stays busy after issue (issue to register-bank write-back)

Ports:
clk1  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  requester has an op
in_ready  out  1  controller accepts op this cycle
in_rs1  in  4  source register 1
in_rs2  in  4  source register 2
in_rd  in  4  destination register
in_func  in  4  ALU function code
in_addr  in  8  memory write address
in_write  in  1  memory write enable for this op
hold  in  1  external stall; no issue while high
out_valid  out  1  issue strobe to pipe, one cycle per op
out_rs1  out  4  issued rs1
out_rs2  out  4  issued rs2
out_rd  out  4  issued rd
out_func  out  4  issued func
out_addr  out  8  issued addr
out_write  out  1  issued write, qualified by out_valid (0 when out_valid=0)
busy  out  16  scoreboard: bit r set while reg r has a write in flight
q_count  out  clog2(QDEPTH)+1  ops held in FIFO

Behaviour:
- Clocking and reset: one clock (clk1); reset synchronous, active-high.
- Reset values: out_valid=0; all out_* fields=0; busy=0; q_count=0; FIFO pointers=0.
  - in_ready=0 while rst=1 (combinational: !rst && q_count<QDEPTH).
- Push: in_valid && in_ready at an edge writes the op at the tail.
  - No push when full: in_ready=0, even if a pop happens the same cycle.
- Head eligible when all hold: q_count>0, hold=0, busy[head.rs1]=0, busy[head.rs2]=0.
  - rs2 is checked for every func, including unary ones.
  - busy[head.rd] is not checked: WAW is safe in the fixed-latency in-order pipe.
- Issue, at the edge where the head is eligible:
  - Pop the head.
  - Register its fields to out_*; out_valid=1 for the following cycle.
  - Load scoreboard counter cnt[rd]=PIPE_LAT.
- Otherwise at each edge: out_valid=0; out_rs1/rs2/rd/func/addr hold their last values; out_write=0.
- Same-edge push and pop: q_count unchanged.
- Empty-FIFO bypass: none. An op accepted at edge E issues at edge E+1 at the earliest; out_valid is high in the cycle after E+1.
- Scoreboard:
  - 16 down-counters, width clog2(PIPE_LAT+1); busy[r] = (cnt[r]!=0).
  - Each edge, every non-zero counter decrements, except the one loaded by an issue at that edge (load wins).
- Back-to-back RAW: producer issued at edge E; dependent issues at edge E+PIPE_LAT+1 at the earliest.
  - Default: out_valid pulses 4 cycles apart, 3 bubbles.
- Independent ops issue on consecutive edges, one per cycle.
- hold=1 blocks issue only; push continues and scoreboard counters keep decrementing.
- Pointer wrap: modulo QDEPTH. Empty/full detection uses q_count, not pointer equality.
- Reset mid-operation: FIFO and scoreboard flushed; ops already in the pipe are not tracked.
- Strict in-order: a stalled head blocks younger independent ops.

Optional Feature:
ISSUE_STATS_EN
- Defined: adds output ports stall_cnt[15:0] and issue_cnt[15:0], both reset to 0 by rst.
  - stall_cnt increments each cycle with q_count>0, hold=0 and the head blocked by the scoreboard.
  - issue_cnt increments on each issue.
  - Both saturate at 16'hFFFF.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
1. Reset with in_valid=1 held -> in_ready=0 during rst, out_valid=0, busy=0, q_count=0. One cycle after rst falls, in_ready=1.
2. Push 3 independent ops (rd=3,4,5; sources 1/2) on consecutive edges, hold=0 -> three consecutive out_valid pulses, fields in order, busy=16'h0038 after the third issue.
3. Op A (rs1=1, rs2=2, rd=3, func=0), then B (rs1=3, rs2=1, rd=4, func=1) -> B's out_valid exactly 4 cycles after A's; with stats, stall_cnt=3.
4. hold=1, push 5 ops -> 4 accepted, in_ready=0, q_count=4, no out_valid. Release hold -> issue 4 ops; the 5th is accepted once in_ready returns; order preserved.
5. rst pulsed for 1 cycle with q_count=3 and busy nonzero -> q_count=0, busy=0, out_valid=0 next cycle; the next pushed op issues normally.
6. Fill and drain 9 ops to wrap pointers twice with mixed hazards -> issue order equals push order, no op lost or duplicated.

Source files
------------

// File: rtl/pipe4_issue_ctrl.sv
// In-order issue controller for the 4-stage ALU pipe: op FIFO, RAW scoreboard, registered issue strobe.
// Optional ISSUE_STATS_EN adds saturating stall_cnt / issue_cnt outputs.
module pipe4_issue_ctrl #(
  parameter int QDEPTH   = 4,
  parameter int PIPE_LAT = 3
) (
  input  logic                      clk1,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3:0]                in_rs1,
  input  logic [3:0]                in_rs2,
  input  logic [3:0]                in_rd,
  input  logic [3:0]                in_func,
  input  logic [7:0]                in_addr,
  input  logic                      in_write,
  input  logic                      hold,
  output logic                      out_valid,
  output logic [3:0]                out_rs1,
  output logic [3:0]                out_rs2,
  output logic [3:0]                out_rd,
  output logic [3:0]                out_func,
  output logic [7:0]                out_addr,
  output logic                      out_write,
  output logic [15:0]               busy,
  output logic [$clog2(QDEPTH):0]   q_count
`ifdef ISSUE_STATS_EN
  ,
  output logic [15:0]               stall_cnt,
  output logic [15:0]               issue_cnt
`endif
);
  localparam int QW  = $clog2(QDEPTH);
  localparam int CW  = $clog2(PIPE_LAT + 1);
  localparam int OPW = 25;
  localparam logic [QW:0]   QFULL = (QW + 1)'(QDEPTH);
  localparam logic [CW-1:0] LAT   = CW'(PIPE_LAT);

  // Packed op layout: {write, addr[7:0], func[3:0], rd[3:0], rs2[3:0], rs1[3:0]}
  logic [OPW-1:0] mem [QDEPTH];
  logic [QW-1:0]  head_ptr;
  logic [QW-1:0]  tail_ptr;
  logic [OPW-1:0] head_op;
  logic [OPW-1:0] in_op;
  logic [CW-1:0]  cnt [16];
  logic           push;
  logic           pop;
  logic           head_blocked;
  logic           not_empty;

  assign in_op        = {in_write, in_addr, in_func, in_rd, in_rs2, in_rs1};
  assign head_op      = mem[head_ptr];
  assign not_empty    = (q_count != '0);
  assign in_ready     = !rst && (q_count != QFULL);
  assign push         = in_valid && in_ready;
  // rd is deliberately not checked: WAW cannot reorder in a fixed-latency in-order pipe.
  assign head_blocked = busy[head_op[3:0]] || busy[head_op[7:4]];
  assign pop          = not_empty && !hold && !head_blocked;

  always_comb begin
    busy = '0;
    for (int r = 0; r < 16; r++) busy[r] = (cnt[r] != '0);
  end

  always_ff @(posedge clk1) begin
    if (push) mem[tail_ptr] <= in_op;
  end

  // Pointers wrap naturally at QDEPTH; fullness comes from q_count only.
  always_ff @(posedge clk1) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      q_count  <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + 1'b1;
      if (pop)  head_ptr <= head_ptr + 1'b1;
      if (push && !pop)      q_count <= q_count + 1'b1;
      else if (pop && !push) q_count <= q_count - 1'b1;
    end
  end

  // A load from an issue at this edge overrides that register's decrement.
  always_ff @(posedge clk1) begin
    for (int r = 0; r < 16; r++) begin
      if (rst)                                 cnt[r] <= '0;
      else if (pop && head_op[11:8] == 4'(r))  cnt[r] <= LAT;
      else if (cnt[r] != '0)                   cnt[r] <= cnt[r] - 1'b1;
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_rs1   <= '0;
      out_rs2   <= '0;
      out_rd    <= '0;
      out_func  <= '0;
      out_addr  <= '0;
      out_write <= 1'b0;
    end else if (pop) begin
      out_valid <= 1'b1;
      {out_write, out_addr, out_func, out_rd, out_rs2, out_rs1} <= head_op;
    end else begin
      out_valid <= 1'b0;
      out_write <= 1'b0;
    end
  end

`ifdef ISSUE_STATS_EN
  always_ff @(posedge clk1) begin
    if (rst) begin
      stall_cnt <= '0;
      issue_cnt <= '0;
    end else begin
      if (not_empty && !hold && head_blocked && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 1'b1;
      if (pop && issue_cnt != 16'hFFFF)
        issue_cnt <= issue_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe4_issue_ctrl.sv
// Bench for pipe4_issue_ctrl: hand-computed vector table, directed corner sequences and
// randomized traffic against a queue/timestamp reference model.
module tb_pipe4_issue_ctrl;
  localparam int QDEPTH   = 4;
  localparam int PIPE_LAT = 3;

  logic       clk1 = 1'b0;
  logic       rst, in_valid, in_ready, in_write, hold;
  logic [3:0] in_rs1, in_rs2, in_rd, in_func;
  logic [7:0] in_addr;
  logic       out_valid, out_write;
  logic [3:0] out_rs1, out_rs2, out_rd, out_func;
  logic [7:0] out_addr;
  logic [15:0] busy;
  logic [2:0]  q_count;
`ifdef ISSUE_STATS_EN
  logic [15:0] stall_cnt, issue_cnt;
  logic [15:0] stall_snap;
`endif

  pipe4_issue_ctrl #(.QDEPTH(QDEPTH), .PIPE_LAT(PIPE_LAT)) dut (
    .clk1(clk1), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_func(in_func),
    .in_addr(in_addr), .in_write(in_write), .hold(hold),
    .out_valid(out_valid), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_func(out_func), .out_addr(out_addr), .out_write(out_write),
    .busy(busy), .q_count(q_count)
`ifdef ISSUE_STATS_EN
    , .stall_cnt(stall_cnt), .issue_cnt(issue_cnt)
`endif
  );

  // clock / reset block
  always #5 clk1 = ~clk1;

  int checks = 0;
  int errors = 0;

  // scoreboard: ops the model has issued, awaiting the DUT strobe
  logic [24:0] exp_q[$];

  // reference model: pending ops as a queue, last issue edge per destination register
  logic [24:0] mq[$];
  int          last_iss[16];
  int          edge_n = 0;
  logic        m_ov = 1'b0;
  logic [24:0] m_out = '0;
  logic        m_pushed = 1'b0;
  int          n_issued = 0;

  typedef struct {
    logic        vld;
    logic [24:0] op;
    logic        hold;
    logic        exp_ov;
    logic [3:0]  exp_rd;
    int          exp_q;
    logic [15:0] exp_busy;
  } vec_t;
  vec_t tbl[13];

  logic [24:0] a1, a2, a3, op_a, op_b, cur;

  function automatic logic [24:0] mk(input int rs1, input int rs2, input int rd,
                                     input int func, input int addr, input int wr);
    return {1'(wr), 8'(addr), 4'(func), 4'(rd), 4'(rs2), 4'(rs1)};
  endfunction

  function automatic logic [24:0] rand_op(input int maxreg);
    return mk($urandom_range(0, maxreg), $urandom_range(0, maxreg), $urandom_range(0, maxreg),
              $urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 1));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic v, input logic [24:0] op, input logic h, input logic r);
    logic        elig;
    logic [24:0] hd;
    logic        rdy;
    edge_n++;
    m_pushed = 1'b0;
    if (r) begin
      mq.delete();
      foreach (last_iss[i]) last_iss[i] = -100;
      m_ov  = 1'b0;
      m_out = '0;
    end else begin
      rdy  = (mq.size() < QDEPTH);
      elig = 1'b0;
      hd   = '0;
      if (mq.size() > 0 && !h) begin
        hd   = mq[0];
        elig = ((edge_n - last_iss[hd[3:0]]) > PIPE_LAT) &&
               ((edge_n - last_iss[hd[7:4]]) > PIPE_LAT);
      end
      if (elig) begin
        void'(mq.pop_front());
        last_iss[hd[11:8]] = edge_n;
        m_ov  = 1'b1;
        m_out = hd;
        exp_q.push_back(hd);
      end else begin
        m_ov      = 1'b0;
        m_out[24] = 1'b0;
      end
      if (v && rdy) begin
        mq.push_back(op);
        m_pushed = 1'b1;
      end
    end
  endtask

  task automatic compare_all(input logic r);
    logic [15:0] eb;
    for (int i = 0; i < 16; i++) eb[i] = ((edge_n - last_iss[i]) < PIPE_LAT);
    chk("out_valid", out_valid, m_ov);
    if (out_valid === 1'b1) begin
      n_issued++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL issue_order: got unexpected issue rd=%0h expected none at %0t", out_rd, $time);
      end else begin
        chk("issued_op", {out_write, out_addr, out_func, out_rd, out_rs2, out_rs1}, exp_q.pop_front());
      end
    end else begin
      chk("out_fields_idle", {out_write, out_addr, out_func, out_rd, out_rs2, out_rs1}, m_out);
    end
    chk("busy", busy, eb);
    chk("q_count", q_count, mq.size());
    chk("in_ready", in_ready, !r && (mq.size() < QDEPTH));
  endtask

  // driver task: apply inputs, advance one edge, update model, check away from the edge
  task automatic cycle(input logic v, input logic [24:0] op, input logic h, input logic r);
    in_valid = v;
    {in_write, in_addr, in_func, in_rd, in_rs2, in_rs1} = op;
    hold = h;
    rst  = r;
    @(posedge clk1);
    model_edge(v, op, h, r);
    #1;
    compare_all(r);
  endtask

  initial begin
    int base;
    int pushed;
    foreach (last_iss[i]) last_iss[i] = -100;

    // 1: reset with in_valid held high
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, mk(1, 2, 3, 4, 5, 1), 1'b0, 1'b1);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_q_count", q_count, 0);
    end
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_busy", busy, 16'h0000);

    // 2 + 3: hand-computed vectors (independent burst, then RAW pair)
    a1   = mk(1, 2, 3, 2, 8'h10, 1);
    a2   = mk(1, 2, 4, 3, 8'h11, 0);
    a3   = mk(1, 2, 5, 4, 8'h12, 1);
    op_a = mk(1, 2, 3, 0, 8'h20, 0);
    op_b = mk(3, 1, 4, 1, 8'h21, 1);
    tbl[0]  = '{1'b1, a1,   1'b0, 1'b0, 4'd0, 1, 16'h0000};
    tbl[1]  = '{1'b1, a2,   1'b0, 1'b1, 4'd3, 1, 16'h0008};
    tbl[2]  = '{1'b1, a3,   1'b0, 1'b1, 4'd4, 1, 16'h0018};
    tbl[3]  = '{1'b0, '0,   1'b0, 1'b1, 4'd5, 0, 16'h0038};
    tbl[4]  = '{1'b0, '0,   1'b0, 1'b0, 4'd0, 0, 16'h0030};
    tbl[5]  = '{1'b0, '0,   1'b0, 1'b0, 4'd0, 0, 16'h0020};
    tbl[6]  = '{1'b0, '0,   1'b0, 1'b0, 4'd0, 0, 16'h0000};
    tbl[7]  = '{1'b1, op_a, 1'b0, 1'b0, 4'd0, 1, 16'h0000};
    tbl[8]  = '{1'b1, op_b, 1'b0, 1'b1, 4'd3, 1, 16'h0008};
    tbl[9]  = '{1'b0, '0,   1'b0, 1'b0, 4'd0, 1, 16'h0008};
    tbl[10] = '{1'b0, '0,   1'b0, 1'b0, 4'd0, 1, 16'h0008};
    tbl[11] = '{1'b0, '0,   1'b0, 1'b0, 4'd0, 1, 16'h0000};
    tbl[12] = '{1'b0, '0,   1'b0, 1'b1, 4'd4, 0, 16'h0010};
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].vld, tbl[i].op, tbl[i].hold, 1'b0);
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].exp_ov);
      chk($sformatf("tbl%0d_q_count", i), q_count, tbl[i].exp_q);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
      if (tbl[i].exp_ov) chk($sformatf("tbl%0d_rd", i), out_rd, tbl[i].exp_rd);
`ifdef ISSUE_STATS_EN
      if (i == 8) stall_snap = stall_cnt;
      if (i == 12) chk("stall_cnt_raw", stall_cnt - stall_snap, 16'd3);
`endif
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b0);

    // 4: hold with five offered ops, then release
    base = n_issued;
    for (int i = 0; i < 5; i++) cycle(1'b1, mk(0, 0, i + 1, i, 8'h40 + i, i % 2), 1'b1, 1'b0);
    chk("hold_q_full", q_count, 4);
    chk("hold_in_ready", in_ready, 1'b0);
    chk("hold_no_issue", out_valid, 1'b0);
    pushed = 0;
    for (int c = 0; c < 20 && pushed == 0; c++) begin
      cycle(1'b1, mk(0, 0, 5, 4, 8'h44, 0), 1'b0, 1'b0);
      if (m_pushed) pushed = 1;
    end
    chk("hold_fifth_accepted", pushed, 1);
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b0, 1'b0);
    chk("hold_issue_total", n_issued - base, 5);

    // 5: reset mid-operation with a full-ish queue and live scoreboard
    for (int i = 0; i < 4; i++) cycle(1'b1, mk(6 + i, 7, 8 + i, 1, i, 1), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("pre_rst_q_count", q_count, 3);
    chk("pre_rst_busy", busy, 16'h0100);
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("mid_rst_q_count", q_count, 0);
    chk("mid_rst_busy", busy, 16'h0000);
    chk("mid_rst_valid", out_valid, 1'b0);
    cycle(1'b1, mk(8, 9, 10, 2, 8'h77, 1), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("post_rst_issue", out_valid, 1'b1);
    chk("post_rst_rd", out_rd, 4'd10);

    // 6: nine ops through the wrapping FIFO with dense register reuse
    base   = n_issued;
    pushed = 0;
    cur    = rand_op(3);
    for (int c = 0; c < 80 && pushed < 9; c++) begin
      cycle(1'b1, cur, $urandom_range(0, 4) == 0, 1'b0);
      if (m_pushed) begin
        pushed++;
        cur = rand_op(3);
      end
    end
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b0, 1'b0);
    chk("wrap_issue_total", n_issued - base, 9);

    // randomized traffic with occasional hold and reset
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 1), rand_op(7), $urandom_range(0, 4) == 0, $urandom_range(0, 99) == 0);
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b0, 1'b0);
    chk("final_backlog", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
